// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : serial_arith_pkg                                             |
// | Description : Shared types and helpers for the bit-serial arithmetic      |
// |               cells. Holds the subtractor FSM state encoding and the      |
// |               step-counter width helper.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package serial_arith_pkg;

  // Controller states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Width of a counter that must reach w-1.
  // Never returns less than one bit, so a degenerate width still yields a legal vector.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : serial_subtractor_if                                         |
// | Description : Start/busy/done handshake and operand/result bus between a  |
// |               controlling FSM (master) and the serial subtractor (slave).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   start : request, sampled by the slave only while idle                   |
// |   a, b  : minuend / subtrahend, captured on an accepted start             |
// |   busy  : high while the slave is shifting                                 |
// |   done  : one-cycle pulse, diff/bout valid                                 |
// |   diff  : a - b modulo 2^WIDTH                                             |
// |   bout  : final borrow, 1 iff a < b (unsigned)                             |
// +----------------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  bout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output bout
  );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : full_subtractor                                              |
// | Description : Single-bit combinational full subtractor, d = a - b - bin.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   a    in  : minuend bit                                                   |
// |   b    in  : subtrahend bit                                                |
// |   bin  in  : borrow in                                                     |
// |   d    out : difference bit                                                |
// |   bout out : borrow out                                                    |
// +----------------------------------------------------------------------------+
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d = a ^ b ^ bin;

  // Borrow when b exceeds a outright, or when the bits tie and a borrow is
  // already pending from the lower slice.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_subtractor                                            |
// | Description : Bit-serial unsigned subtractor. Computes a - b LSB-first,    |
// |               one bit per clock, through one full-subtractor slice with a |
// |               registered borrow. Start/busy/done handshake.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk   in  : rising-edge clock                                            |
// |   rst_n in  : asynchronous active-low reset                                |
// |   bus   slave modport of serial_subtractor_if:                             |
// |           start, a, b in ; busy, done, diff, bout out                      |
// | Timing                                                                     |
// |   start sampled at edge E0, WIDTH shift edges E1..E_WIDTH, done high in   |
// |   the following cycle; start-to-start throughput is WIDTH+2 cycles.       |
// +----------------------------------------------------------------------------+
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q,   bout_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             fs_d;
  logic             fs_bo;
  logic [WIDTH-1:0] res_shifted;

  // The one and only bit-slice; it always looks at the current LSBs.
  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bo)
  );

  // The new difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has arrived at bit 0.
  assign res_shifted = {fs_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        res_d    = res_shifted;
        borrow_d = fs_bo;
        if (cnt_q == LAST_CNT) begin
          // Publish the result only on the final step so diff/bout keep the
          // previous answer for the whole operation. The counter is left
          // alone here and never wraps.
          diff_d  = res_shifted;
          bout_d  = fs_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded straight from the state register.
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule : serial_subtractor
`default_nettype wire
